// File: rtl/fft16_frame_ctrl.sv
// Streaming frame sequencer around a combinational 16-point radix-2 DIT FFT.
// Samples land bit-reversed in the input buffer, results stream out in natural order.

module fft16 #(
  parameter int DW = 64
) (
  input  logic [15:0][DW-1:0] x_re,
  input  logic [15:0][DW-1:0] x_im,
  output logic [15:0][DW-1:0] y_re,
  output logic [15:0][DW-1:0] y_im
);
  localparam int CW = DW + 17;

  // Twiddles W16^k = cos - j*sin in Q14; 1.0 is exactly 16384 so trivial twiddles are lossless.
  function automatic logic signed [15:0] tw_c(input int k);
    case (k)
      0: tw_c = 16'sd16384;
      1: tw_c = 16'sd15137;
      2: tw_c = 16'sd11585;
      3: tw_c = 16'sd6270;
      4: tw_c = 16'sd0;
      5: tw_c = -16'sd6270;
      6: tw_c = -16'sd11585;
      7: tw_c = -16'sd15137;
      default: tw_c = 16'sd0;
    endcase
  endfunction

  function automatic logic signed [15:0] tw_s(input int k);
    case (k)
      0: tw_s = 16'sd0;
      1: tw_s = -16'sd6270;
      2: tw_s = -16'sd11585;
      3: tw_s = -16'sd15137;
      4: tw_s = -16'sd16384;
      5: tw_s = -16'sd15137;
      6: tw_s = -16'sd11585;
      7: tw_s = -16'sd6270;
      default: tw_s = 16'sd0;
    endcase
  endfunction

  function automatic logic [DW-1:0] cm_re(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b,
                                          input logic signed [15:0] c, input logic signed [15:0] d);
    logic signed [CW-1:0] p;
    p = CW'(a) * CW'(c) - CW'(b) * CW'(d);
    cm_re = DW'(p >>> 14);
  endfunction

  function automatic logic [DW-1:0] cm_im(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b,
                                          input logic signed [15:0] c, input logic signed [15:0] d);
    logic signed [CW-1:0] p;
    p = CW'(a) * CW'(d) + CW'(b) * CW'(c);
    cm_im = DW'(p >>> 14);
  endfunction

  logic [4:0][15:0][DW-1:0] sr, si;

  assign sr[0] = x_re;
  assign si[0] = x_im;
  assign y_re  = sr[4];
  assign y_im  = si[4];

  for (genvar s = 0; s < 4; s++) begin : g_st
    localparam int SP = 1 << s;
    for (genvar i = 0; i < 16; i++) begin : g_bf
      localparam int LO = i & ~SP;
      localparam int HI = i | SP;
      localparam int K  = (HI & (SP - 1)) << (3 - s);
      logic [DW-1:0] tr, ti;
      assign tr = cm_re(sr[s][HI], si[s][HI], tw_c(K), tw_s(K));
      assign ti = cm_im(sr[s][HI], si[s][HI], tw_c(K), tw_s(K));
      if ((i & SP) == 0) begin : g_add
        assign sr[s+1][i] = sr[s][LO] + tr;
        assign si[s+1][i] = si[s][LO] + ti;
      end else begin : g_sub
        assign sr[s+1][i] = sr[s][LO] - tr;
        assign si[s+1][i] = si[s][LO] - ti;
      end
    end
  end
endmodule

module fft16_frame_ctrl #(
  parameter int DW            = 64,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_re,
  input  logic [DW-1:0] s_im,
  input  logic          s_last,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_re,
  output logic [DW-1:0] m_im,
  output logic [3:0]    m_idx,
  output logic          m_last,
  output logic          busy,
  output logic          frame_err
);
  typedef enum logic [1:0] {LOAD, SETTLE, CAPTURE, UNLOAD} state_t;

  state_t state, state_nxt;
  logic [15:0][DW-1:0] ibuf_re, ibuf_im, obuf_re, obuf_im, fft_re, fft_im;
  logic [3:0] wr_idx, rd_idx, set_cnt;
  logic s_hs, m_hs, set_done;

  function automatic logic [3:0] bitrev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  fft16 #(.DW(DW)) u_fft (
    .x_re (ibuf_re),
    .x_im (ibuf_im),
    .y_re (fft_re),
    .y_im (fft_im)
  );

  assign s_ready  = (state == LOAD);
  assign m_valid  = (state == UNLOAD);
  assign s_hs     = s_valid & s_ready;
  assign m_hs     = m_valid & m_ready;
  assign m_re     = obuf_re[rd_idx];
  assign m_im     = obuf_im[rd_idx];
  assign m_idx    = rd_idx;
  assign m_last   = m_valid & (rd_idx == 4'd15);
  assign busy     = !((state == LOAD) && (wr_idx == 4'd0));
  assign set_done = (set_cnt == 4'(SETTLE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (s_hs && wr_idx == 4'd15) state_nxt = SETTLE;
      SETTLE:  if (set_done) state_nxt = CAPTURE;
      CAPTURE: state_nxt = UNLOAD;
      UNLOAD:  if (m_hs && rd_idx == 4'd15) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ibuf_re   <= '0;
      ibuf_im   <= '0;
      obuf_re   <= '0;
      obuf_im   <= '0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      set_cnt   <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        LOAD: if (s_hs) begin
          ibuf_re[bitrev4(wr_idx)] <= s_re;
          ibuf_im[bitrev4(wr_idx)] <= s_im;
          // A short frame is dropped; stale slots are overwritten by the next full frame.
          if (wr_idx == 4'd15) begin
            wr_idx <= '0;
          end else if (s_last) begin
            wr_idx    <= '0;
            frame_err <= 1'b1;
          end else begin
            wr_idx <= wr_idx + 4'd1;
          end
        end
        SETTLE:  set_cnt <= set_done ? 4'd0 : set_cnt + 4'd1;
        CAPTURE: begin
          obuf_re <= fft_re;
          obuf_im <= fft_im;
          rd_idx  <= '0;
        end
        UNLOAD:  if (m_hs) rd_idx <= rd_idx + 4'd1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fft16_frame_ctrl.sv
// Directed bench for fft16_frame_ctrl: impulse, constant, bit-reversal, backpressure,
// short frame and reset during unload, with hand-derived spectra.

module tb_fft16_frame_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b0;
  logic [63:0] s_re = '0, s_im = '0;
  logic        s_ready, m_valid, m_last, busy, frame_err;
  logic [63:0] m_re, m_im;
  logic [3:0]  m_idx;

  int n_chk = 0, n_pass = 0;
  logic [63:0] xr[16], xi[16], er[16], ei[16];

  fft16_frame_ctrl #(.DW(64), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_re(m_re), .m_im(m_im),
    .m_idx(m_idx), .m_last(m_last), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_const(input logic [63:0] re, input logic [63:0] im);
    for (int n = 0; n < 16; n++) begin
      xr[n] = re; xi[n] = im;
      er[n] = '0; ei[n] = '0;
    end
    er[0] = re << 4;
    ei[0] = im << 4;
  endtask

  task automatic set_impulse(input int pos);
    for (int n = 0; n < 16; n++) begin
      xr[n] = (n == pos) ? 64'd1 : 64'd0; xi[n] = '0;
      er[n] = (pos == 8 && n[0]) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd1;
      ei[n] = '0;
    end
  endtask

  task automatic send(input int nsamp, input int last_at);
    for (int n = 0; n < nsamp; n++) begin
      check("s_ready_load", 64'(s_ready), 64'd1);
      s_valid = 1'b1; s_re = xr[n]; s_im = xi[n]; s_last = (n == last_at);
      tick();
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_valid();
    int lat = 0;
    while (!m_valid && lat < 50) begin
      tick();
      lat++;
    end
    check("latency", 64'(lat), 64'd3);
  endtask

  task automatic recv(input int nb, input bit bp);
    int bin = 0, cyc = 0;
    while (bin < nb && cyc < 200) begin
      m_ready = bp ? (cyc % 3 == 0) : 1'b1;
      if (m_valid) begin
        check("s_ready_unload", 64'(s_ready), 64'd0);
        check("m_re", m_re, er[bin]);
        check("m_im", m_im, ei[bin]);
        check("m_idx", 64'(m_idx), 64'(bin));
        check("m_last", 64'(m_last), 64'(bin == 15));
        if (m_ready) bin++;
      end
      tick();
      cyc++;
    end
    m_ready = 1'b0;
    if (bin < nb) check("recv_timeout", 64'(bin), 64'(nb));
  endtask

  task automatic post_frame();
    check("m_valid_after", 64'(m_valid), 64'd0);
    check("s_ready_after", 64'(s_ready), 64'd1);
    check("busy_after", 64'(busy), 64'd0);
  endtask

  task automatic full_frame(input bit bp);
    send(16, 15);
    check("busy_settle", 64'(busy), 64'd1);
    wait_valid();
    recv(16, bp);
    post_frame();
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) tick();
    check("rst_s_ready", 64'(s_ready), 64'd1);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_last", 64'(m_last), 64'd0);
    check("rst_m_idx", 64'(m_idx), 64'd0);
    check("rst_m_re", m_re, 64'd0);
    check("rst_m_im", m_im, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    rst = 1'b0;
    tick();

    set_impulse(0);
    full_frame(1'b0);

    set_const(64'd3, 64'd2);
    full_frame(1'b0);

    set_impulse(8);
    full_frame(1'b0);

    set_const(64'd5, 64'hFFFF_FFFF_FFFF_FFFF);
    full_frame(1'b1);

    set_impulse(0);
    send(6, 5);
    check("frame_err_pulse", 64'(frame_err), 64'd1);
    check("busy_after_err", 64'(busy), 64'd0);
    tick();
    check("frame_err_clear", 64'(frame_err), 64'd0);
    repeat (5) begin
      check("no_output_err", 64'(m_valid), 64'd0);
      tick();
    end
    full_frame(1'b0);

    set_const(64'd1, 64'd0);
    send(16, 15);
    wait_valid();
    recv(7, 1'b0);
    rst = 1'b1;
    tick();
    check("mid_rst_m_valid", 64'(m_valid), 64'd0);
    check("mid_rst_s_ready", 64'(s_ready), 64'd1);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_m_idx", 64'(m_idx), 64'd0);
    rst = 1'b0;
    tick();

    set_const(64'd2, 64'd1);
    full_frame(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
